// File: rtl/fifo_sync_param.sv
// Parametrised show-ahead synchronous FIFO with any depth, occupancy count and level flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module fifo_sync_param #(
    parameter int BITS   = 8,
    parameter int DEPTH  = 4,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [BITS-1:0] Din,
    output logic [BITS-1:0] Dout,
    output logic            full,
    output logic            pndng,
    output logic [CW-1:0]   count,
    output logic            almost_full,
    output logic            almost_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic            err_clr,
    output logic            overflow,
    output logic            underflow
`endif
);

    logic [BITS-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pop_acc;
    logic            push_acc;

    assign full         = (count == CW'(DEPTH));
    assign pndng        = (count != '0);
    assign almost_full  = (count >= CW'(AF_LVL));
    assign almost_empty = (count <= CW'(AE_LVL));
    assign Dout         = pndng ? mem[rd_ptr] : '0;

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign pop_acc  = pop & pndng;
    assign push_acc = push & (~full | pop_acc);

    // Explicit wrap keeps non-power-of-two depths in range
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_acc) begin
            mem[wr_ptr] <= Din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_acc && !pop_acc)      count <= count + CW'(1);
            else if (pop_acc && !push_acc) count <= count - CW'(1);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky flags: a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (push & ~push_acc) | (overflow & ~err_clr);
            underflow <= (pop & ~pndng) | (underflow & ~err_clr);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised and directed bench for fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int BITS = 8;
    localparam int DEPTH = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            push = 1'b0;
    logic            pop = 1'b0;
    logic [BITS-1:0] Din = '0;
    logic [BITS-1:0] Dout;
    logic            full;
    logic            pndng;
    logic [CW-1:0]   count;
    logic            almost_full;
    logic            almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic            err_clr = 1'b0;
    logic            overflow;
    logic            underflow;
    logic            m_ovf = 1'b0;
    logic            m_unf = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [BITS-1:0] q[$];

    fifo_sync_param #(
        .BITS(BITS), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .Din(Din),
        .Dout(Dout), .full(full), .pndng(pndng), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    // One clock: drive, let the edge happen, update the queue model, settle
    task automatic step(input logic p, input logic o, input logic [BITS-1:0] d);
        bit pa, wa;
        push = p;
        pop = o;
        Din = d;
        @(posedge clk);
        pa = o && (q.size() > 0);
        wa = p && (q.size() < DEPTH || pa);
`ifdef FIFO_ERR_FLAGS_EN
        m_ovf = (p && !wa) || (m_ovf && !err_clr);
        m_unf = (o && q.size() == 0) || (m_unf && !err_clr);
`endif
        if (pa) void'(q.pop_front());
        if (wa) q.push_back(d);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
`ifdef FIFO_ERR_FLAGS_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        checks++;
        if ({Dout, full, pndng, count, almost_full, almost_empty} !==
            {8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: dout=%h full=%b pndng=%b cnt=%0d af=%b ae=%b, want 00 0 0 0 0 1",
                     Dout, full, pndng, count, almost_full, almost_empty);
        end
    endtask

    task automatic test_basic;
        logic [BITS-1:0] d[3] = '{8'h11, 8'h22, 8'h33};
        int exp_cnt[6] = '{1, 2, 3, 2, 1, 0};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, d[i]);
            checks++;
            if (count !== CW'(exp_cnt[i])) begin
                errors++;
                $display("FAIL basic_push_cnt[%0d]: got %0d want %0d", i, count, exp_cnt[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (Dout !== d[i]) begin
                errors++;
                $display("FAIL basic_dout[%0d]: got %h want %h", i, Dout, d[i]);
            end
            step(1'b0, 1'b1, '0);
            checks++;
            if (count !== CW'(exp_cnt[i+3])) begin
                errors++;
                $display("FAIL basic_pop_cnt[%0d]: got %0d want %0d", i, count, exp_cnt[i+3]);
            end
        end
        checks++;
        if (pndng !== 1'b0 || Dout !== 8'h00) begin
            errors++;
            $display("FAIL basic_end: pndng=%b dout=%h want 0 00", pndng, Dout);
        end
    endtask

    task automatic test_overfill;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'hA0 + 8'(i));
            if (i == 4) begin
                checks++;
                if (full !== 1'b1) begin
                    errors++;
                    $display("FAIL overfill_full: got %b want 1", full);
                end
            end
        end
        checks++;
        if (count !== CW'(5) || full !== 1'b1) begin
            errors++;
            $display("FAIL overfill_cnt: cnt=%0d full=%b want 5 1", count, full);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b want 1", overflow);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (Dout !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL overfill_drain[%0d]: got %h want %h", i, Dout, 8'hA0 + 8'(i));
            end
            step(1'b0, 1'b1, '0);
        end
    endtask

    task automatic test_full_pushpop;
        logic [BITS-1:0] popped[$];
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
        for (int i = 0; i < 7; i++) begin
            popped.push_back(Dout);
            step(1'b1, 1'b1, 8'hBB);
            checks++;
            if (count !== CW'(5) || full !== 1'b1) begin
                errors++;
                $display("FAIL fullpp_cnt[%0d]: cnt=%0d full=%b want 5 1", i, count, full);
            end
        end
        for (int i = 0; i < 5; i++) begin
            popped.push_back(Dout);
            step(1'b0, 1'b1, '0);
        end
        for (int i = 0; i < 12; i++) begin
            logic [BITS-1:0] want;
            want = (i < 5) ? 8'hC0 + 8'(i) : 8'hBB;
            checks++;
            if (popped[i] !== want) begin
                errors++;
                $display("FAIL fullpp_order[%0d]: got %h want %h", i, popped[i], want);
            end
        end
    endtask

    task automatic test_empty_pushpop;
        step(1'b1, 1'b1, 8'h5A);
        checks++;
        if (count !== CW'(1) || Dout !== 8'h5A) begin
            errors++;
            $display("FAIL empty_pp: cnt=%0d dout=%h want 1 5a", count, Dout);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL empty_pp_unf: got %b want 1", underflow);
        end
`endif
        step(1'b0, 1'b1, '0);
    endtask

    task automatic test_flags;
        for (int n = 0; n <= 10; n++) begin
            int c;
            c = (n <= 5) ? n : 10 - n;
            checks++;
            if (count !== CW'(c) || almost_full !== (c >= AF) || almost_empty !== (c <= AE)) begin
                errors++;
                $display("FAIL flags[%0d]: cnt=%0d af=%b ae=%b want %0d %b %b",
                         n, count, almost_full, almost_empty, c, c >= AF, c <= AE);
            end
            if (n < 5) step(1'b1, 1'b0, 8'(n));
            else if (n < 10) step(1'b0, 1'b1, '0);
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h70 + 8'(i));
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({Dout, full, pndng, count, almost_full, almost_empty} !==
            {8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_rst: dout=%h full=%b pndng=%b cnt=%0d af=%b ae=%b",
                     Dout, full, pndng, count, almost_full, almost_empty);
        end
        #2;
        rst = 1'b0;
        q.delete();
`ifdef FIFO_ERR_FLAGS_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        @(posedge clk);
        #1;
    endtask

`ifdef FIFO_ERR_FLAGS_EN
    task automatic test_err_flags;
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_sticky: got %b want 1", underflow);
        end
        err_clr = 1'b1;
        step(1'b0, 1'b1, '0);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_set_wins: got %b want 1", underflow);
        end
        step(1'b0, 1'b0, '0);
        err_clr = 1'b0;
        checks++;
        if (underflow !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: unf=%b ovf=%b want 0 0", underflow, overflow);
        end
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            logic [BITS-1:0] wd;
            logic [BITS-1:0] ed;
            wd = 8'($urandom);
`ifdef FIFO_ERR_FLAGS_EN
            err_clr = ($urandom_range(0, 9) == 0);
`endif
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ^ (i > 200), wd);
            ed = (q.size() > 0) ? q[0] : '0;
            checks++;
            if (Dout !== ed || count !== CW'(q.size()) || full !== (q.size() == DEPTH) ||
                pndng !== (q.size() > 0) || almost_full !== (q.size() >= AF) ||
                almost_empty !== (q.size() <= AE)) begin
                errors++;
                $display("FAIL random[%0d]: dout=%h cnt=%0d full=%b pndng=%b af=%b ae=%b want dout=%h cnt=%0d",
                         i, Dout, count, full, pndng, almost_full, almost_empty, ed, q.size());
            end
`ifdef FIFO_ERR_FLAGS_EN
            checks++;
            if (overflow !== m_ovf || underflow !== m_unf) begin
                errors++;
                $display("FAIL random_err[%0d]: ovf=%b unf=%b want %b %b",
                         i, overflow, underflow, m_ovf, m_unf);
            end
`endif
        end
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overfill;
        test_full_pushpop;
        test_empty_pushpop;
        test_flags;
        test_async_reset;
`ifdef FIFO_ERR_FLAGS_EN
        test_err_flags;
`endif
        test_random;
        test_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO, flop-array storage, single clock domain. Next generation of the team's push/pop FIFO.
- Adds several features over the previous FIFO:
  - arbitrary (non-power-of-two) depth;
  - occupancy count output;
  - programmable almost-full and almost-empty flags;
  - simultaneous push/pop when full;
  - optional sticky error flags.
- Sits between producer/consumer blocks as an elastic buffer. Read data is show-ahead: the head word is always visible on Dout.

Parameters:
- BITS, 8: data word width, >=1.
- DEPTH, 4: number of entries, >=2. Need not be a power of two.
- AF_LVL, DEPTH-1: almost_full asserts when count >= AF_LVL. Legal range 1..DEPTH.
- AE_LVL, 1: almost_empty asserts when count <= AE_LVL. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  write request; Din is captured when the push is accepted.
- pop  in  1  read request; the head entry is removed when the pop is accepted.
- Din  in  BITS  write data.
- Dout  out  BITS  head-of-queue data, combinational from storage.
- full  out  1  count == DEPTH.
- pndng  out  1  count > 0.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_LVL.
- almost_empty  out  1  count <= AE_LVL.

Behaviour:
- Reset: one clock; rst is asynchronous, active-high, and takes effect immediately regardless of clk.
  - Clears wr_ptr, rd_ptr, count and all storage to 0.
  - Outputs during and after reset: Dout=0, full=0, pndng=0, count=0, almost_full=0, almost_empty=1. AE_LVL>=0, so almost_empty=1 at reset.
  - rst asserted mid-operation discards all contents; no partial write completes.
- Acceptance, evaluated on the registered state at the clock edge:
  - pop_acc = pop & pndng.
  - push_acc = push & (~full | pop_acc). A push while full is accepted only if a pop is accepted in the same cycle.
- Edge update:
  - If push_acc: mem[wr_ptr] <= Din, and wr_ptr advances.
  - If pop_acc: rd_ptr advances.
  - count <= count + push_acc - pop_acc, computed in count width with no wrap.
- Pointers: $clog2(DEPTH) bits each. They wrap from DEPTH-1 to 0 by explicit compare, not natural overflow. This is required for non-power-of-two DEPTH.
- Latency:
  - A word pushed at edge N appears on Dout after edge N, when the FIFO was empty.
  - pndng rises in the same cycle.
  - Write-to-read latency is one cycle; there is no same-cycle fall-through.
- Dout = mem[rd_ptr] when pndng=1, else 0. After an accepted pop, Dout shows the next entry combinationally following the edge.
- Boundary conditions:
  - Push while full with no pop: ignored; storage, pointers and count are unchanged.
  - Pop while empty: ignored, including when push is also high. In that case only the push is accepted and count goes 0->1.
  - Push and pop both accepted: count is unchanged; both pointers advance, with wrap applied independently.
- Flags are all combinational from registered count; no extra flag latency.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, three extra ports are added:
  - err_clr  in  1.
  - overflow  out  1, sticky: set on any cycle with push & ~push_acc.
  - underflow  out  1, sticky: set on any cycle with pop & ~pndng.
- Flag rules:
  - Both flags reset to 0.
  - Both flags are cleared synchronously by err_clr=1.
  - If err_clr and a set condition occur in the same cycle, set wins.
- When not defined: these ports and registers do not exist; illegal requests are silently ignored. Core behaviour is identical in both builds.

Test Plan (BITS=8, DEPTH=5, AF_LVL=4, AE_LVL=1):
1. Reset, then push 0x11,0x22,0x33 on consecutive cycles, then pop three times -> Dout sequence 0x11,0x22,0x33. count goes 1,2,3,2,1,0. pndng=0 and Dout=0 at the end.
2. Push 6 words 0xA0..0xA5 with no pop -> full=1 after the 5th; the 6th is ignored and count stays 5. Popping five times returns 0xA0..0xA4.
3. Fill to 5, then assert push=pop=1 with Din=0xBB for 7 cycles -> count stays 5, full stays 1. Pointers wrap. The final drain order ends with seven 0xBB entries as the last popped words, in order.
4. Empty FIFO, push=pop=1 with Din=0x5A -> pop ignored, count=1, Dout=0x5A next cycle.
5. Step count 0->5->0 -> almost_empty=1 for count 0..1, almost_full=1 for count 4..5. Transitions occur exactly at those counts.
6. Assert rst asynchronously mid-cycle at count=3 -> all outputs reach reset values before the next clk edge.
   - With FIFO_ERR_FLAGS_EN: pop on empty -> underflow=1 and it stays set; err_clr clears it.
